// File: rtl/pcm_cic_interp_pkg.sv
// Shared sizing and arithmetic helpers for the PCM CIC interpolator.
package pcm_cic_interp_pkg;

   // Working width for the saturating clamp; wide enough for any legal accumulator.
   localparam int SAT_W = 128;

   function automatic int acc_width(input int in_w, input int order, input int rate_log2);
      return in_w + order * rate_log2;
   endfunction

   // CIC interpolator gain is R^(N-1); dividing by it gives unity DC gain.
   function automatic int gain_shift(input int order, input int rate_log2);
      return (order - 1) * rate_log2;
   endfunction

   function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                          input int out_w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
      lo = ~hi;
      if (v > hi) return hi;
      else if (v < lo) return lo;
      else return v;
   endfunction

endpackage

// File: rtl/pcm_cic_integ_stage.sv
// One CIC integrator: modular accumulator that advances only on enabled cycles.
module pcm_cic_integ_stage #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] add_i,
   output logic [W-1:0] acc_o
);
   logic [W-1:0] acc_q;
   logic [W-1:0] acc_d;

   assign acc_d = acc_q + add_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else if (en) begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/pcm_cic_interp.sv
// CIC interpolator: PCM in at one slot per 2^RATE_LOG2 enabled clks, one sample out per enabled clk, ORDER+2 cycle latency.
// A slot without in_valid feeds zero and latches underrun; PCM_CIC_INTERP_SAT_EN clamps instead of wrapping the output.
module pcm_cic_interp
   import pcm_cic_interp_pkg::*;
#(
   parameter int IN_W      = 24,
   parameter int OUT_W     = 24,
   parameter int ORDER     = 3,
   parameter int RATE_LOG2 = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   output logic             underrun,
   input  logic             clr_underrun
);
   localparam int ACC_W = acc_width(IN_W, ORDER, RATE_LOG2);
   localparam int SHIFT = gain_shift(ORDER, RATE_LOG2);

   logic [RATE_LOG2-1:0]    phase_q, phase_d;
   logic                    slot;
   logic [ACC_W-1:0]        x;
   logic [ACC_W-1:0]        dly_q [ORDER];
   logic [ACC_W-1:0]        dly_d [ORDER];
   logic [ACC_W-1:0]        comb_out;
   logic [ACC_W-1:0]        stuff_q, stuff_d;
   logic [ACC_W-1:0]        integ [ORDER+1];
   logic signed [ACC_W-1:0] y;
   logic signed [SAT_W-1:0] y_ext, y_lim;
   logic                    unused_y_hi;
   logic [OUT_W-1:0]        out_data_q, out_data_d;
   logic                    out_valid_q;
   logic                    underrun_q, underrun_d;

   assign phase_d  = phase_q + RATE_LOG2'(1);
   assign in_ready = (phase_q == '0);
   assign slot     = en & in_ready;
   assign x        = in_valid ? {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data} : '0;

   // Comb chain runs at the slot rate, so its delays only capture on a slot.
   always_comb begin
      logic [ACC_W-1:0] c;
      c = x;
      for (int k = 0; k < ORDER; k++) begin
         dly_d[k] = c;
         c        = c - dly_q[k];
      end
      comb_out = c;
   end

   assign stuff_d  = slot ? comb_out : '0;
   assign integ[0] = stuff_q;

   for (genvar k = 0; k < ORDER; k++) begin : g_integ
      pcm_cic_integ_stage #(.W(ACC_W)) u_stage (
         .clk   (clk),
         .rst   (rst),
         .en    (en),
         .add_i (integ[k]),
         .acc_o (integ[k+1])
      );
   end

   assign y     = $signed(integ[ORDER]) >>> SHIFT;
   assign y_ext = SAT_W'(y);
`ifdef PCM_CIC_INTERP_SAT_EN
   assign y_lim = sat_signed(y_ext, OUT_W);
`else
   assign y_lim = y_ext;
`endif
   assign out_data_d  = y_lim[OUT_W-1:0];
   assign unused_y_hi = ^y_lim[SAT_W-1:OUT_W];

   // A new underrun outranks a simultaneous clear.
   assign underrun_d = (slot & ~in_valid) | (underrun_q & ~clr_underrun);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q     <= '0;
         stuff_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
         for (int k = 0; k < ORDER; k++) dly_q[k] <= '0;
      end else begin
         out_valid_q <= en;
         underrun_q  <= underrun_d;
         if (en) begin
            phase_q    <= phase_d;
            stuff_q    <= stuff_d;
            out_data_q <= out_data_d;
         end
         if (slot) begin
            for (int k = 0; k < ORDER; k++) dly_q[k] <= dly_d[k];
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_pcm_cic_interp.sv
// Directed bench for pcm_cic_interp (ORDER=3, RATE_LOG2=3, IN_W=24, OUT_W=16).
module tb_pcm_cic_interp;
   logic        clk;
   logic        rst;
   logic        en;
   logic [23:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        underrun;
   logic        clr_underrun;

   int total = 0;
   int bad   = 0;
   int ec;
   int sum;
   int rdy_cnt;
   logic en_cur;
   logic [31:0] exp_v;

   // (1 + z^-1 + ... + z^-7)^3 taps; impulse of 4096 gives 64 * tap after the /64 gain shift.
   int h [22] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48, 48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

`ifdef PCM_CIC_INTERP_SAT_EN
   localparam logic [31:0] SAT_EXP = 32'h0000_7FFF;
`else
   localparam logic [31:0] SAT_EXP = 32'h0000_9C40;
`endif

   pcm_cic_interp #(
      .IN_W      (24),
      .OUT_W     (16),
      .ORDER     (3),
      .RATE_LOG2 (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .underrun     (underrun),
      .clr_underrun (clr_underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; in_data = '0; in_valid = 1'b0; clr_underrun = 1'b0;
      #12;
      check("rst_out",      32'(out_data),  32'd0);
      check("rst_vld",      32'(out_valid), 32'd0);
      check("rst_underrun", 32'(underrun),  32'd1 - 32'd1);
      check("rst_ready",    32'(in_ready),  32'd1);
      rst = 1'b0;

      // Impulse with a 5-cycle enable stall in the middle of the response.
      ec = 0; sum = 0;
      for (int s = 0; s < 40; s++) begin
         en       = !(s >= 12 && s < 17);
         in_valid = 1'b1;
         in_data  = (s == 0) ? 24'd4096 : 24'd0;
         en_cur   = en;
         step();
         if (en_cur) ec++;
         exp_v = (ec >= 5 && ec <= 26) ? 32'(64 * h[ec-5]) : 32'd0;
         check("imp_out", 32'(out_data),  exp_v);
         check("imp_vld", 32'(out_valid), 32'(en_cur));
         check("imp_rdy", 32'(in_ready),  32'((ec % 8) == 0));
         if (en_cur) sum += int'($signed(out_data));
      end
      check("imp_sum",      32'(sum),      32'd32768);
      check("imp_underrun", 32'(underrun), 32'd0);

      // DC 1000 on every slot.
      en = 1'b1; in_data = 24'd1000; rdy_cnt = 0;
      for (int s = 0; s < 60; s++) begin
         if (s >= 44 && in_ready) rdy_cnt++;
         step(); ec++;
         if (s >= 52) check("dc_out", 32'(out_data), 32'd1000);
      end
      check("dc_ready_rate", 32'(rdy_cnt), 32'd2);

      // Underrun: set, sticky, set beats clear, clear alone.
      while ((ec % 8) != 0) begin step(); ec++; end
      in_valid = 1'b0;
      step(); ec++;
      check("ur_set", 32'(underrun), 32'd1);
      in_valid = 1'b1;
      for (int s = 0; s < 3; s++) begin step(); ec++; end
      check("ur_sticky", 32'(underrun), 32'd1);
      while ((ec % 8) != 0) begin step(); ec++; end
      in_valid = 1'b0; clr_underrun = 1'b1;
      step(); ec++;
      check("ur_set_wins", 32'(underrun), 32'd1);
      in_valid = 1'b1;
      step(); ec++;
      check("ur_clear", 32'(underrun), 32'd0);
      clr_underrun = 1'b0;

      // Re-arm underrun, then reset asynchronously away from any clock edge.
      while ((ec % 8) != 0) begin step(); ec++; end
      in_valid = 1'b0;
      step(); ec++;
      in_valid = 1'b1;
      step(); ec++;
      step(); ec++;
      check("ur_rearm", 32'(underrun), 32'd1);
      check("pre_rst_ready", 32'(in_ready), 32'd0);
      #3 rst = 1'b1;
      #1;
      check("arst_out",      32'(out_data),  32'd0);
      check("arst_underrun", 32'(underrun),  32'd0);
      check("arst_ready",    32'(in_ready),  32'd1);
      check("arst_vld",      32'(out_valid), 32'd0);
      rst = 1'b0;

      // DC 40000 exceeds the 16-bit output range: clamps or wraps depending on the build.
      ec = 0; in_data = 24'd40000; in_valid = 1'b1; en = 1'b1;
      for (int s = 0; s < 50; s++) begin
         step(); ec++;
         if (s >= 42) check("big_dc_out", 32'(out_data), SAT_EXP);
      end
      check("big_dc_vld", 32'(out_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
